// File: rtl/data_mem_responder.sv
// Single-ported data memory slave with 33-bit tagged words and a fixed-latency, in-order response pipeline.
// Optional SECDED(39,32) data integrity is enabled by defining DATA_MEM_RESP_INTG_EN.
module data_mem_responder #(
  parameter int unsigned AddrW          = 12,
  parameter logic [31:0] BaseAddr       = 32'h2000_0000,
  parameter int unsigned RespLat        = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_is_cap_i,
  input  logic [32:0] data_wdata_i,
  input  logic [6:0]  data_wdata_intg_i,
  output logic        data_rvalid_o,
  output logic [32:0] data_rdata_o,
  output logic [6:0]  data_rdata_intg_o,
  output logic        data_err_o
);

  localparam int unsigned Words   = 2 ** AddrW;
  localparam logic [32:0] EndAddr = {1'b0, BaseAddr} + (33'(Words) << 2);

  typedef struct packed {
    logic        vld;
    logic        err;
    logic [32:0] data;
    logic [6:0]  intg;
  } rsp_t;

`ifdef DATA_MEM_RESP_INTG_EN
  function automatic logic [6:0] secded_39_32(input logic [31:0] d);
    logic [6:0] c;
    c[0] = ^(d & 32'h2606_BD25);
    c[1] = ^(d & 32'hDEBA_8050);
    c[2] = ^(d & 32'h413D_89AA);
    c[3] = ^(d & 32'h3123_4ED1);
    c[4] = ^(d & 32'hC2C1_323B);
    c[5] = ^(d & 32'h2DCC_624C);
    c[6] = ^(d & 32'h9850_5586);
    return c;
  endfunction
`endif

  logic [32:0]      mem_q [Words];
  rsp_t             pipe_q [RespLat];
  logic [2:0]       cnt_q;
  logic [2:0]       cnt_d;

  logic             gnt_s;
  logic             in_range_s;
  logic [31:0]      offset_s;
  logic [AddrW-1:0] idx_s;
  logic             wintg_ok_s;
  logic             wr_en_s;
  logic             tag_s;
  rsp_t             new_rsp_s;
  rsp_t             last_s;
  logic             unused_s;

  assign gnt_s      = data_req_i & ~rst_i & (cnt_q < 3'(MaxOutstanding));
  assign data_gnt_o = gnt_s;

  assign in_range_s = (data_addr_i >= BaseAddr) && ({1'b0, data_addr_i} < EndAddr);
  assign offset_s   = data_addr_i - BaseAddr;
  assign idx_s      = offset_s[AddrW+1:2];

`ifdef DATA_MEM_RESP_INTG_EN
  assign wintg_ok_s = (data_wdata_intg_i == secded_39_32(data_wdata_i[31:0]));
`else
  assign wintg_ok_s = 1'b1;
`endif

  assign wr_en_s = gnt_s & data_we_i & in_range_s & wintg_ok_s;
  // The capability tag survives only a full-word capability store.
  assign tag_s   = data_is_cap_i & (data_be_i == 4'hF) & data_wdata_i[32];

  always_comb begin
    new_rsp_s = '0;
    if (gnt_s) begin
      new_rsp_s.vld = 1'b1;
      new_rsp_s.err = ~in_range_s | (data_we_i & ~wintg_ok_s);
      if (~data_we_i && in_range_s) begin
        new_rsp_s.data = mem_q[idx_s];
      end else begin
        new_rsp_s.data = 33'h0;
      end
`ifdef DATA_MEM_RESP_INTG_EN
      new_rsp_s.intg = secded_39_32(new_rsp_s.data[31:0]);
`else
      new_rsp_s.intg = 7'h0;
`endif
    end else begin
      new_rsp_s = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      for (int b = 0; b < 4; b++) begin
        if (data_be_i[b]) begin
          mem_q[idx_s][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
      mem_q[idx_s][32] <= tag_s;
    end
  end

  assign last_s = pipe_q[RespLat-1];

  always_comb begin
    cnt_d = cnt_q;
    case ({gnt_s, last_s.vld})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(RespLat); i++) begin
        pipe_q[i] <= '0;
      end
      cnt_q <= 3'd0;
    end else begin
      pipe_q[0] <= new_rsp_s;
      for (int i = 1; i < int'(RespLat); i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      cnt_q <= cnt_d;
    end
  end

  // Outputs are forced quiet for the whole reset cycle, not just after the first edge.
  assign data_rvalid_o     = last_s.vld & ~rst_i;
  assign data_err_o        = last_s.err & ~rst_i;
  assign data_rdata_o      = rst_i ? 33'h0 : last_s.data;
  assign data_rdata_intg_o = rst_i ? 7'h0 : last_s.intg;

  assign unused_s = ^{data_addr_i[1:0], offset_s[31:AddrW+2], data_wdata_intg_i};

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter AddrW, default 12: memory holds 2^AddrW words of 33 bits (bit 32 = capability tag).
REQ-002 Parameter BaseAddr, default 32'h2000_0000: byte address of word 0.
REQ-003 Parameter RespLat, default 1, legal 1..4: cycles from grant to rvalid.
REQ-004 Parameter MaxOutstanding, default 2, legal 1..4: granted-but-unanswered request limit.
REQ-005 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_i  in  1  reset, synchronous, active-high.
REQ-007 data_req_i  in  1  request valid.
REQ-008 data_gnt_o  out  1  request accepted this cycle.
REQ-009 data_we_i  in  1  1 = write, 0 = read.
REQ-010 data_be_i  in  4  byte enables.
REQ-011 data_addr_i  in  32  byte address; bits [1:0] ignored.
REQ-012 data_is_cap_i  in  1  capability access.
REQ-013 data_wdata_i  in  33  write data; bit 32 = tag.
REQ-014 data_wdata_intg_i  in  7  write-data integrity.
REQ-015 data_rvalid_o  out  1  response valid.
REQ-016 data_rdata_o  out  33  read data; bit 32 = tag.
REQ-017 data_rdata_intg_o  out  7  read-data integrity.
REQ-018 data_err_o  out  1  response error; qualified by data_rvalid_o.

Function
REQ-019 data_gnt_o is combinational: data_req_i AND outstanding count < MaxOutstanding.
REQ-020 Grant cycle: address, we, be, is_cap, wdata captured; writes commit to the array at the end of the grant cycle; reads sample the array in the grant cycle.
REQ-021 data_rvalid_o asserts exactly RespLat cycles after the grant cycle for one cycle; responses return in grant order; back-to-back grants give back-to-back responses.
REQ-022 Outstanding counter: +1 on grant, -1 on rvalid, unchanged when both occur in the same cycle; never exceeds MaxOutstanding and never wraps below 0.
REQ-023 In-range: BaseAddr <= addr < BaseAddr + 4*2^AddrW; word index = (addr - BaseAddr) >> 2.
REQ-024 Out-of-range request: granted normally; no array update; response has data_err_o = 1 and data_rdata_o = 0.
REQ-025 Write data: only bytes with data_be_i set are updated; data_be_i = 0 updates no data bytes.
REQ-026 Tag on write: tag <= data_wdata_i[32] only when data_is_cap_i = 1 and data_be_i = 4'hF; every other in-range write clears the tag.
REQ-027 Read response: data_rdata_o = {tag, word}; data_err_o = 0.
REQ-028 Read in the cycle after a write to the same word returns the new value.
REQ-029 data_rdata_o and data_err_o hold 0 when data_rvalid_o = 0.

Reset
REQ-030 While rst_i = 1: data_rvalid_o = 0, data_err_o = 0, data_rdata_o = 0, data_rdata_intg_o = 0, outstanding count = 0, response pipeline cleared.
REQ-031 While rst_i = 1, data_gnt_o = 0.
REQ-032 Reset during outstanding requests: pending responses are discarded and never emitted; writes already granted remain committed.
REQ-033 Memory array contents are not reset.

Configuration
REQ-034 Macro DATA_MEM_RESP_INTG_EN defined: data_rdata_intg_o = SECDED(39,32) check bits of data_rdata_o[31:0] on valid responses.
REQ-035 DATA_MEM_RESP_INTG_EN defined: a granted write whose data_wdata_intg_i mismatches SECDED(39,32) of data_wdata_i[31:0] causes no array update and returns data_err_o = 1.
REQ-036 DATA_MEM_RESP_INTG_EN undefined: data_rdata_intg_o = 7'h0 and data_wdata_intg_i is ignored.

Verification
REQ-037 RespLat=1: write 0x2000_0010 be=F is_cap=1 wdata=33'h1_DEAD_BEEF, then read -> rvalid next cycle, rdata=33'h1_DEAD_BEEF, err=0.
REQ-038 Same word: write be=4'b0011 wdata=0x0000_1234 is_cap=0, then read -> rdata=33'h0_DEAD_1234 (tag cleared).
REQ-039 MaxOutstanding=2, RespLat=3, req held high -> gnt high in cycles 0 and 1, low in cycles 2 and 3, high again in cycle 4 alongside the first rvalid in cycle 3.
REQ-040 Read at 0x1FFF_FFFC and at BaseAddr+4*2^AddrW -> both rvalid with err=1, rdata=0; array unchanged.
REQ-041 rst_i pulsed one cycle after granting a read with RespLat=2 -> no rvalid follows; count=0; next request granted immediately.
REQ-042 With DATA_MEM_RESP_INTG_EN: write with wdata_intg=7'h00 for a wdata whose correct check bits are nonzero -> err=1, subsequent read returns old value with correct intg.
